// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style multi-cycle control FSM for the LEGv8 core.
// Sequences fetch/decode/exec/mem/writeback and counts retired instructions.
`default_nettype none

module multicycle_ctrl #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [10:0]        opcode,
  input  logic               alu_zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic               reg2_loc,
  output logic               alu_src,
  output logic [3:0]         alu_op,
  output logic               dmem_read,
  output logic               dmem_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               retire,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ADD  = 4'd0,
    C_SUB  = 4'd1,
    C_AND  = 4'd2,
    C_ORR  = 4'd3,
    C_LDUR = 4'd4,
    C_STUR = 4'd5,
    C_CBZ  = 4'd6,
    C_B    = 4'd7,
    C_ILL  = 4'd8
  } cls_t;

  state_t cur;
  cls_t   cls_r;
  cls_t   cls_dec;
  cls_t   cls_cur;
  logic   rearm;   // set by an illegal opcode; run must go low before fetching again

  always_comb begin
    cls_dec = C_ILL;
    if      (opcode == 11'h458)      cls_dec = C_ADD;
    else if (opcode == 11'h658)      cls_dec = C_SUB;
    else if (opcode == 11'h450)      cls_dec = C_AND;
    else if (opcode == 11'h550)      cls_dec = C_ORR;
    else if (opcode == 11'h7C2)      cls_dec = C_LDUR;
    else if (opcode == 11'h7C0)      cls_dec = C_STUR;
    else if (opcode[10:3] == 8'hB4)  cls_dec = C_CBZ;
    else if (opcode[10:5] == 6'h05)  cls_dec = C_B;
  end

  // The class register is only loaded on DECODE exit, so DECODE itself uses the live decode.
  assign cls_cur = (cur == DECODE) ? cls_dec : cls_r;
  assign state   = cur;

  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg2_loc   = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 4'b0000;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    case (cur)
      FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      DECODE: begin
        if (cls_dec == C_B) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
          retire   = 1'b1;
        end
      end
      EXEC: begin
        case (cls_cur)
          C_ADD:  alu_op = 4'b0010;
          C_SUB:  alu_op = 4'b0110;
          C_AND:  alu_op = 4'b0000;
          C_ORR:  alu_op = 4'b0001;
          C_LDUR, C_STUR: begin
            alu_op  = 4'b0010;
            alu_src = 1'b1;
          end
          C_CBZ: begin
            alu_op   = 4'b0111;
            pc_write = 1'b1;
            pc_src   = alu_zero;
            retire   = 1'b1;
          end
          default: alu_op = 4'b0000;
        endcase
      end
      MEM: begin
        dmem_read  = (cls_cur == C_LDUR);
        dmem_write = (cls_cur == C_STUR);
        if (cls_cur == C_STUR && dmem_ready) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_cur == C_LDUR);
        pc_write   = 1'b1;
        retire     = 1'b1;
      end
      default: ;
    endcase
    if ((cur == DECODE || cur == EXEC || cur == MEM || cur == WB) &&
        (cls_cur == C_STUR || cls_cur == C_CBZ))
      reg2_loc = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= IDLE;
      cls_r       <= C_ILL;
      illegal_op  <= 1'b0;
      rearm       <= 1'b0;
      instr_count <= '0;
    end else begin
      if (!run) rearm <= 1'b0;
      if (cur == DECODE) cls_r <= cls_dec;
      if (retire) begin
        instr_count <= instr_count + COUNT_W'(1);
        cur         <= run ? FETCH : IDLE;
      end else begin
        case (cur)
          IDLE:   if (run && !rearm) cur <= FETCH;
          FETCH:  if (imem_ready) cur <= DECODE;
          DECODE: begin
            if (cls_dec == C_ILL) begin
              illegal_op <= 1'b1;
              rearm      <= 1'b1;
              cur        <= IDLE;
            end else begin
              cur <= EXEC;
            end
          end
          EXEC:   cur <= (cls_r == C_LDUR || cls_r == C_STUR) ? MEM : WB;
          MEM:    if (dmem_ready) cur <= WB;
          WB:     cur <= IDLE;
          default: cur <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven per-cycle checks of multicycle_ctrl plus
// hand-written reset-in-MEM and counter-wrap sequences.
`default_nettype none

module tb_multicycle_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, run, alu_zero, imem_ready, dmem_ready;
  logic [10:0]   opcode;
  logic          imem_req, ir_write, pc_write, pc_src, reg2_loc, alu_src;
  logic [3:0]    alu_op;
  logic          dmem_read, dmem_write, mem_to_reg, reg_write, retire, illegal_op;
  logic [CW-1:0] instr_count;
  logic [2:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl #(.COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg2_loc(reg2_loc),
    .alu_src(alu_src), .alu_op(alu_op), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .retire(retire),
    .illegal_op(illegal_op), .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  // Control bundle bit positions
  localparam logic [15:0] IR  = 16'h8000, IW = 16'h4000, PW = 16'h2000, PS = 16'h1000;
  localparam logic [15:0] R2  = 16'h0800, AS = 16'h0400;
  localparam logic [15:0] A_ADD = 16'h0080, A_PB = 16'h01C0;
  localparam logic [15:0] DR  = 16'h0020, DW = 16'h0010, M2R = 16'h0008;
  localparam logic [15:0] RW  = 16'h0004, RET = 16'h0002, ILL = 16'h0001;

  localparam logic [10:0] OP_ADD = 11'h458, OP_LDUR = 11'h7C2, OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_CBZ = 11'h5A0, OP_B = 11'h0A0, OP_BAD = 11'h000;

  typedef struct {
    logic          rst_n, run;
    logic [10:0]   op;
    logic          az, imr, dmr;
    logic [2:0]    st;
    logic [15:0]   ctl;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] ctl_now();
    return {imem_req, ir_write, pc_write, pc_src, reg2_loc, alu_src, alu_op,
            dmem_read, dmem_write, mem_to_reg, reg_write, retire, illegal_op};
  endfunction

  task automatic v(input logic r, input logic ru, input logic [10:0] op,
                   input logic az, input logic imr, input logic dmr,
                   input logic [2:0] st, input logic [15:0] ctl, input logic [CW-1:0] cnt);
    vec_t e;
    e.rst_n = r; e.run = ru; e.op = op; e.az = az; e.imr = imr; e.dmr = dmr;
    e.st = st; e.ctl = ctl; e.cnt = cnt;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = 11'h0; alu_zero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;

    //    rst run opcode   az imr dmr  st    ctl                          cnt
    v(0, 0, OP_ADD,  0, 0, 0, 3'd0, 16'h0,                       4'd0); // reset
    v(1, 0, OP_ADD,  0, 0, 0, 3'd0, 16'h0,                       4'd0);
    v(1, 1, OP_ADD,  0, 0, 0, 3'd0, 16'h0,                       4'd0);
    v(1, 1, OP_ADD,  0, 0, 0, 3'd1, IR,                          4'd0); // imem wait
    v(1, 1, OP_ADD,  0, 1, 0, 3'd1, IR|IW,                       4'd0);
    v(1, 1, OP_ADD,  0, 1, 0, 3'd2, 16'h0,                       4'd0);
    v(1, 1, OP_ADD,  0, 1, 0, 3'd3, A_ADD,                       4'd0);
    v(1, 1, OP_ADD,  0, 1, 0, 3'd5, RW|PW|RET,                   4'd0);
    // LDUR with three dmem wait cycles
    v(1, 1, OP_LDUR, 0, 1, 0, 3'd1, IR|IW,                       4'd1);
    v(1, 1, OP_LDUR, 0, 1, 0, 3'd2, 16'h0,                       4'd1);
    v(1, 1, OP_LDUR, 0, 1, 0, 3'd3, A_ADD|AS,                    4'd1);
    v(1, 1, OP_LDUR, 0, 1, 0, 3'd4, DR,                          4'd1);
    v(1, 1, OP_LDUR, 0, 1, 0, 3'd4, DR,                          4'd1);
    v(1, 1, OP_LDUR, 0, 1, 0, 3'd4, DR,                          4'd1);
    v(1, 1, OP_LDUR, 0, 1, 1, 3'd4, DR,                          4'd1);
    v(1, 1, OP_LDUR, 0, 1, 1, 3'd5, RW|M2R|PW|RET,               4'd1);
    // STUR zero-wait
    v(1, 1, OP_STUR, 0, 1, 1, 3'd1, IR|IW,                       4'd2);
    v(1, 1, OP_STUR, 0, 1, 1, 3'd2, R2,                          4'd2);
    v(1, 1, OP_STUR, 0, 1, 1, 3'd3, R2|AS|A_ADD,                 4'd2);
    v(1, 1, OP_STUR, 0, 1, 1, 3'd4, R2|DW|PW|RET,                4'd2);
    // CBZ taken then not taken
    v(1, 1, OP_CBZ,  1, 1, 0, 3'd1, IR|IW,                       4'd3);
    v(1, 1, OP_CBZ,  1, 1, 0, 3'd2, R2,                          4'd3);
    v(1, 1, OP_CBZ,  1, 1, 0, 3'd3, R2|A_PB|PW|PS|RET,           4'd3);
    v(1, 1, OP_CBZ,  0, 1, 0, 3'd1, IR|IW,                       4'd4);
    v(1, 1, OP_CBZ,  0, 1, 0, 3'd2, R2,                          4'd4);
    v(1, 1, OP_CBZ,  0, 1, 0, 3'd3, R2|A_PB|PW|RET,              4'd4);
    // illegal opcode, then run toggle to resume
    v(1, 1, OP_BAD,  0, 1, 0, 3'd1, IR|IW,                       4'd5);
    v(1, 1, OP_BAD,  0, 1, 0, 3'd2, 16'h0,                       4'd5);
    v(1, 1, OP_B,    0, 1, 0, 3'd0, ILL,                         4'd5);
    v(1, 1, OP_B,    0, 1, 0, 3'd0, ILL,                         4'd5);
    v(1, 0, OP_B,    0, 1, 0, 3'd0, ILL,                         4'd5);
    v(1, 1, OP_B,    0, 1, 0, 3'd0, ILL,                         4'd5);
    v(1, 1, OP_B,    0, 1, 0, 3'd1, IR|IW|ILL,                   4'd5);
    v(1, 1, OP_B,    0, 1, 0, 3'd2, PW|PS|RET|ILL,               4'd5);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; run = vecs[i].run; opcode = vecs[i].op;
      alu_zero = vecs[i].az; imem_ready = vecs[i].imr; dmem_ready = vecs[i].dmr;
      #1;
      chk($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("vec%0d ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d count", i), 32'(instr_count), 32'(vecs[i].cnt));
    end

    // Reset asserted while a STUR is waiting in MEM
    @(negedge clk);
    opcode = OP_STUR; imem_ready = 1'b1; dmem_ready = 1'b0;
    chk("stur fetch state", 32'(state), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("mem wait state", 32'(state), 32'd4);
    chk("mem wait dmem_write", 32'(dmem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset state", 32'(state), 32'd0);
    chk("async reset dmem_write", 32'(dmem_write), 32'd0);
    chk("async reset count", 32'(instr_count), 32'd0);
    chk("async reset illegal", 32'(illegal_op), 32'd0);

    // Counter wrap with 16 B instructions, run dropped during the last one
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1; opcode = OP_B; imem_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("wrap%0d fetch state", k), 32'(state), 32'd1);
      chk($sformatf("wrap%0d count", k), 32'(instr_count), 32'(k));
      if (k == 15) run = 1'b0;
      @(negedge clk);
      #1;
      chk($sformatf("wrap%0d retire", k), 32'(retire), 32'd1);
    end
    @(negedge clk);
    #1;
    chk("wrap final state", 32'(state), 32'd0);
    chk("wrap final count", 32'(instr_count), 32'd0);
    @(negedge clk);
    #1;
    chk("idle hold state", 32'(state), 32'd0);
    chk("idle hold imem_req", 32'(imem_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style multi-cycle control FSM for the LEGv8 core. It sequences instruction fetch, decode, execute, memory and writeback.
- It consumes the 11-bit opcode produced by the instruction field splitter from the registered IR, plus ALU-zero and memory-ready handshakes.
- It drives IR/PC/register-file/memory enables, ALU op and mux selects, and counts retired instructions.

Parameters:
- COUNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = execute instructions, 0 = stop at next retirement
- opcode  in  11  opcode field of current IR (valid from DECODE onward)
- alu_zero  in  1  ALU zero flag (sampled in EXEC)
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load IR from imem data
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = branch target
- reg2_loc  out  1  1 = read port 2 uses Rd field (STUR/CBZ)
- alu_src  out  1  1 = ALU B from sign-extended address
- alu_op  out  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B
- dmem_read  out  1  data memory read strobe
- dmem_write  out  1  data memory write strobe
- mem_to_reg  out  1  1 = writeback from memory
- reg_write  out  1  register file write enable
- retire  out  1  one-cycle pulse when an instruction completes
- illegal_op  out  1  sticky flag, undefined opcode decoded
- instr_count  out  COUNT_W  retired instruction count
- state  out  3  current state encoding, for debug

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Values 6/7 are unreachable and recover to IDLE.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, instr_count=0, illegal_op=0.
  - All outputs are decoded from state, so every control output is 0 while in reset.
- Opcode classes, decoded from the opcode input and registered on DECODE exit:
  - ADD 11'h458, SUB 11'h658, AND 11'h450, ORR 11'h550.
  - LDUR 11'h7C2, STUR 11'h7C0.
  - CBZ: opcode[10:3]=8'hB4.
  - B: opcode[10:5]=6'h05.
  - Anything else is illegal.
- IDLE: all controls 0. Go to FETCH when run=1.
- FETCH: imem_req=1 and hold while imem_ready=0. ir_write=1 in the same cycle imem_ready=1, then go to DECODE.
- DECODE:
  - B: pc_write=1, pc_src=1, retire.
  - Illegal: set illegal_op, pc_write=0, go to IDLE; no retire, no count. run must drop and rise again to resume.
  - Otherwise go to EXEC.
  - reg2_loc is asserted from DECODE through the end of the instruction for STUR and CBZ.
- EXEC:
  - alu_op per class: LDUR/STUR use ADD with alu_src=1; CBZ uses pass-B.
  - R-type goes to WB; LDUR/STUR go to MEM.
  - CBZ: pc_write=1, pc_src=alu_zero, retire.
- MEM:
  - dmem_read (LDUR) or dmem_write (STUR) is held until dmem_ready=1.
  - LDUR then goes to WB.
  - STUR retires in the dmem_ready cycle with pc_write=1, pc_src=0.
- WB: reg_write=1, mem_to_reg=1 for LDUR, pc_write=1, pc_src=0, retire.
- Retire cycle:
  - retire=1 and instr_count increments by 1, wrapping modulo 2^COUNT_W.
  - Next state is FETCH if run=1, else IDLE.
  - run deasserted mid-instruction never aborts that instruction.
- Minimum latency with zero-wait memory (FETCH to retire inclusive): B 2, CBZ 3, R-type 4, STUR 4, LDUR 5 cycles. Each ready wait cycle adds 1.
- Clearing illegal_op: only by reset.
- Reset mid-instruction: immediate return to IDLE, and no write strobes in the reset cycle.

Test Plan:
- Reset with rst_n=0 mid-MEM and dmem_write=1 -> same edge: state=0, dmem_write=0, instr_count=0.
- run=1; ADD 11'h458 with imem_ready=1 -> states 1,2,3,5; alu_op=0010 in EXEC; reg_write=1 in WB; retire once; count=1.
- LDUR 11'h7C2 with dmem_ready held low for 3 cycles -> dmem_read high for 4 cycles; mem_to_reg=1 and reg_write=1 in WB; total 8 cycles.
- CBZ 11'h5A0 with alu_zero=1 -> pc_src=1 in EXEC. Then alu_zero=0 -> pc_src=0; retires in 3 cycles each.
- Opcode 11'h000 -> illegal_op=1, state returns to IDLE, count unchanged. run toggle resumes fetch.
- Counter wrap: COUNT_W=4, 16 B instructions (11'h0A0) -> instr_count 15 -> 0. run=0 during the last one -> IDLE after retire.
